// File: rtl/pio_bank_pkg.sv
// -----------------------------------------------------------------------------
// pio_bank_pkg
// Shared constants for the pio_bank general-purpose I/O peripheral:
//   - Avalon-MM word addresses of the register map
//   - edge capture mode encodings
//   - clog2 helper used to size the debounce counters
// -----------------------------------------------------------------------------
package pio_bank_pkg;

   // Register map (word addresses); 6 and 7 are unused and read as zero
   localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
   localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
   localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

   // Edge capture modes
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   // Ceiling of log2(n) for n >= 2, i.e. the bits needed to count 0..n-1
   function automatic int clog2(input int unsigned n);
      int          result;
      int unsigned top;
      result = 0;
      top    = n - 1;
      for (int i = 0; i < 32; i++) begin
         if ((top >> i) != 0) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pio_debounce.sv
// -----------------------------------------------------------------------------
// pio_debounce
// Single-bit debouncer placed after the input synchroniser. The stable output
// only follows sync_in once sync_in has held one value for DB_CYCLES clocks,
// so glitches shorter than the window never reach the edge detector.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sync_in    in   synchronised input bit
//   stable_out out  debounced bit
// -----------------------------------------------------------------------------
module pio_debounce
   import pio_bank_pkg::*;
#(
   parameter int DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic stable_out
);

   localparam int              CNT_W   = clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync_prev_q, sync_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // The update compares against the counter's next value so that a change on
   // sync_in (which forces the counter to 0) can never be accepted in the same
   // cycle it first appears, even when the counter was saturated.
   always_comb begin
      sync_prev_d = sync_in;
      cnt_d       = cnt_q;
      stable_d    = stable_q;
      if (sync_in != sync_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      if ((cnt_d == CNT_MAX) && (sync_in != stable_q)) begin
         stable_d = sync_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_prev_q <= 1'b0;
         cnt_q       <= '0;
         stable_q    <= 1'b0;
      end else begin
         sync_prev_q <= sync_prev_d;
         cnt_q       <= cnt_d;
         stable_q    <= stable_d;
      end
   end

   assign stable_out = stable_q;

endmodule

// File: rtl/pio_bank.sv
// -----------------------------------------------------------------------------
// pio_bank
// Parametrised GPIO peripheral on an Avalon-MM slave: one conditioned input
// group with edge capture and a level interrupt, and one output register with
// atomic set/clear writes. Reads have a fixed latency of one clock.
//
// Optional feature macro: PIO_BANK_DEBOUNCE_EN
//   defined   - each input bit gets a pio_debounce stage after the synchroniser
//   undefined - the synchroniser output feeds the edge detector directly
//
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   avs_address    in   word address (3 bits)
//   avs_read       in   read strobe
//   avs_write      in   write strobe (wins over a simultaneous read)
//   avs_writedata  in   write data (32 bits)
//   avs_readdata   out  registered read data, held until the next read
//   irq            out  level interrupt, |(EDGE_CAP & IRQ_MASK) registered
//   pio_in         in   asynchronous external inputs (IN_WIDTH bits)
//   pio_out        out  output register (OUT_WIDTH bits)
// -----------------------------------------------------------------------------
module pio_bank
   import pio_bank_pkg::*;
#(
   parameter int          IN_WIDTH  = 10,
   parameter int          OUT_WIDTH = 32,
   parameter int          EDGE_MODE = 0,
   parameter logic [31:0] OUT_RESET = 32'h0,
   parameter int          DB_CYCLES = 50000
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   output logic                 irq,
   input  logic [IN_WIDTH-1:0]  pio_in,
   output logic [OUT_WIDTH-1:0] pio_out
);

   localparam logic [OUT_WIDTH-1:0] OUT_RST = OUT_RESET[OUT_WIDTH-1:0];

   logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
   logic [IN_WIDTH-1:0]  cond;
   logic [IN_WIDTH-1:0]  cond_prev_q;
   logic [IN_WIDTH-1:0]  edges;
   logic [IN_WIDTH-1:0]  mask_q, mask_d;
   logic [IN_WIDTH-1:0]  cap_q, cap_d;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic                 irq_q, irq_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [IN_WIDTH-1:0]  wr_in;
   logic [OUT_WIDTH-1:0] wr_out;

`ifdef PIO_BANK_DEBOUNCE_EN
   for (genvar i = 0; i < IN_WIDTH; i++) begin : g_debounce
      pio_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .clk        (clk_clk),
         .rst_n      (reset_reset_n),
         .sync_in    (sync2_q[i]),
         .stable_out (cond[i])
      );
   end
`else
   assign cond = sync2_q;
`endif

   // Edge detection against the conditioned value one cycle earlier
   always_comb begin
      edges = '0;
      if (EDGE_MODE == EDGE_FALL) begin
         edges = ~cond & cond_prev_q;
      end else if (EDGE_MODE == EDGE_BOTH) begin
         edges = cond ^ cond_prev_q;
      end else begin
         edges = cond & ~cond_prev_q;
      end
   end

   // Register writes, read mux and interrupt; a newly detected edge is OR-ed
   // in after the write-1-to-clear so the edge survives a same-cycle clear.
   always_comb begin
      wr_in   = avs_writedata[IN_WIDTH-1:0];
      wr_out  = avs_writedata[OUT_WIDTH-1:0];
      out_d   = out_q;
      mask_d  = mask_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      if (avs_write) begin
         case (avs_address)
            ADDR_DATA_OUT: out_d  = wr_out;
            ADDR_IRQ_MASK: mask_d = wr_in;
            ADDR_EDGE_CAP: cap_d  = cap_q & ~wr_in;
            ADDR_OUT_SET:  out_d  = out_q | wr_out;
            ADDR_OUT_CLR:  out_d  = out_q & ~wr_out;
            default:       ;
         endcase
      end else if (avs_read) begin
         rdata_d = '0;
         case (avs_address)
            ADDR_DATA_IN:  rdata_d[IN_WIDTH-1:0]  = cond;
            ADDR_DATA_OUT: rdata_d[OUT_WIDTH-1:0] = out_q;
            ADDR_IRQ_MASK: rdata_d[IN_WIDTH-1:0]  = mask_q;
            ADDR_EDGE_CAP: rdata_d[IN_WIDTH-1:0]  = cap_q;
            default:       ;
         endcase
      end
      cap_d = cap_d | edges;
      irq_d = |(cap_q & mask_q);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         cond_prev_q <= '0;
         mask_q      <= '0;
         cap_q       <= '0;
         out_q       <= OUT_RST;
         irq_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         sync1_q     <= pio_in;
         sync2_q     <= sync1_q;
         cond_prev_q <= cond;
         mask_q      <= mask_d;
         cap_q       <= cap_d;
         out_q       <= out_d;
         irq_q       <= irq_d;
         rdata_q     <= rdata_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = irq_q;
   assign pio_out      = out_q;

endmodule

// File: tb/tb_pio_bank.sv
// -----------------------------------------------------------------------------
// tb_pio_bank
// Directed self-checking bench for pio_bank (IN_WIDTH=10, OUT_WIDTH=32,
// EDGE_MODE=rising, OUT_RESET=0xFF, DB_CYCLES=8). Expected latencies follow
// PIO_BANK_DEBOUNCE_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_pio_bank;

   localparam int          IN_WIDTH  = 10;
   localparam int          OUT_WIDTH = 32;
   localparam int          DB_CYCLES = 8;
   localparam logic [31:0] OUT_RESET = 32'h0000_00FF;

`ifdef PIO_BANK_DEBOUNCE_EN
   localparam int          CONDLAT   = 2 + DB_CYCLES;
   localparam logic [31:0] PULSE_CAP = 32'h0;
`else
   localparam int          CONDLAT   = 2;
   localparam logic [31:0] PULSE_CAP = 32'h8;
`endif
   localparam int LAT = CONDLAT + 1;

   logic                 clk_clk = 1'b0;
   logic                 reset_reset_n;
   logic [2:0]           avs_address;
   logic                 avs_read;
   logic                 avs_write;
   logic [31:0]          avs_writedata;
   logic [31:0]          avs_readdata;
   logic                 irq;
   logic [IN_WIDTH-1:0]  pio_in;
   logic [OUT_WIDTH-1:0] pio_out;

   int assertCount = 0;
   int failCount   = 0;
   logic [31:0] rd;

   pio_bank #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .EDGE_MODE (0),
      .OUT_RESET (OUT_RESET),
      .DB_CYCLES (DB_CYCLES)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .pio_in        (pio_in),
      .pio_out       (pio_out)
   );

   // 10 ns system clock
   always #5 clk_clk = ~clk_clk;

   // Advance n rising edges and settle 1 ns past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   // Drive the external inputs
   task automatic applyStimulus(input logic [IN_WIDTH-1:0] value);
      pio_in = value;
   endtask

   // One comparison: counts it and reports a failure with observed/expected
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Single-cycle write; takes effect on the next rising edge
   task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(posedge clk_clk);
      #1;
      avs_write     = 1'b0;
   endtask

   // Single-cycle read; data is valid just after the next rising edge
   task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
      avs_address = addr;
      avs_read    = 1'b1;
      @(posedge clk_clk);
      #1;
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   initial begin
      reset_reset_n = 1'b0;
      avs_address   = '0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_writedata = '0;
      applyStimulus('0);

      // Reset values
      tick(2);
      checkOutput("rst_pio_out", pio_out, 32'h0000_00FF);
      checkOutput("rst_irq", {31'b0, irq}, 32'h0);
      checkOutput("rst_readdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;
      tick(2);
      busRead(3'd0, rd);
      checkOutput("data_in_idle", rd, 32'h0);

      // Output register: plain write, set, clear, readback
      busWrite(3'd1, 32'h0F0);
      checkOutput("out_write", pio_out, 32'h0F0);
      busWrite(3'd4, 32'h00F);
      checkOutput("out_set", pio_out, 32'h0FF);
      busWrite(3'd5, 32'h030);
      checkOutput("out_clr", pio_out, 32'h0CF);
      busRead(3'd1, rd);
      checkOutput("out_readback", rd, 32'h0CF);
      tick(3);
      checkOutput("readdata_hold", avs_readdata, 32'h0CF);

      // Simultaneous read and write: write wins, readdata untouched
      avs_address   = 3'd1;
      avs_writedata = 32'h55;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      tick(1);
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      checkOutput("rw_pio_out", pio_out, 32'h55);
      checkOutput("rw_readdata", avs_readdata, 32'h0CF);

      // Unused addresses
      busWrite(3'd7, 32'hFFFF_FFFF);
      checkOutput("addr7_ignored", pio_out, 32'h55);
      busRead(3'd6, rd);
      checkOutput("addr6_zero", rd, 32'h0);

      // Mask width limited to IN_WIDTH
      busWrite(3'd2, 32'hFFFF_FFFF);
      busRead(3'd2, rd);
      checkOutput("mask_width", rd, 32'h3FF);
      busWrite(3'd2, 32'h001);

      // Rising edge on bit0: capture after LAT cycles, irq one cycle later
      applyStimulus(10'h001);
      tick(LAT - 1);
      checkOutput("edge_irq_early", {31'b0, irq}, 32'h0);
      busRead(3'd3, rd);
      checkOutput("edge_cap_early", rd, 32'h0);
      checkOutput("edge_irq_wait", {31'b0, irq}, 32'h0);
      busRead(3'd3, rd);
      checkOutput("edge_cap_set", rd, 32'h001);
      checkOutput("edge_irq_set", {31'b0, irq}, 32'h1);

      // W1C drops irq on the following cycle
      busWrite(3'd3, 32'h001);
      checkOutput("w1c_irq_lag", {31'b0, irq}, 32'h1);
      tick(1);
      checkOutput("w1c_irq_drop", {31'b0, irq}, 32'h0);

      // Falling edge is ignored in rising mode
      applyStimulus(10'h000);
      tick(LAT + 2);
      busRead(3'd3, rd);
      checkOutput("fall_ignored", rd, 32'h0);

      // Re-arm, then W1C coinciding with a fresh rising edge: edge wins
      applyStimulus(10'h001);
      tick(LAT + 1);
      checkOutput("rearm_irq", {31'b0, irq}, 32'h1);
      applyStimulus(10'h000);
      tick(LAT + 2);
      checkOutput("rearm_irq_hold", {31'b0, irq}, 32'h1);
      applyStimulus(10'h001);
      tick(LAT - 1);
      busWrite(3'd3, 32'h001);
      checkOutput("collide_irq_0", {31'b0, irq}, 32'h1);
      tick(1);
      checkOutput("collide_irq_1", {31'b0, irq}, 32'h1);
      busRead(3'd3, rd);
      checkOutput("collide_cap", rd, 32'h001);

      // Clearing the mask drops irq next cycle
      busWrite(3'd2, 32'h0);
      checkOutput("mask_clr_lag", {31'b0, irq}, 32'h1);
      tick(1);
      checkOutput("mask_clr_drop", {31'b0, irq}, 32'h0);

      // Fill EDGE_CAP, then reset asynchronously while inputs are settling
      busWrite(3'd2, 32'h3FF);
      applyStimulus(10'h000);
      tick(LAT + 2);
      applyStimulus(10'h3FF);
      tick(LAT + 2);
      busRead(3'd3, rd);
      checkOutput("cap_all", rd, 32'h3FF);
      checkOutput("cap_all_irq", {31'b0, irq}, 32'h1);
      applyStimulus(10'h000);
      tick(3);
      #3;
      reset_reset_n = 1'b0;
      #1;
      checkOutput("async_rst_pio_out", pio_out, 32'h0000_00FF);
      checkOutput("async_rst_irq", {31'b0, irq}, 32'h0);
      checkOutput("async_rst_readdata", avs_readdata, 32'h0);
      tick(1);
      reset_reset_n = 1'b1;
      tick(LAT + 4);
      checkOutput("post_rst_irq", {31'b0, irq}, 32'h0);
      busRead(3'd3, rd);
      checkOutput("post_rst_cap", rd, 32'h0);
      busRead(3'd2, rd);
      checkOutput("post_rst_mask", rd, 32'h0);
      busRead(3'd0, rd);
      checkOutput("post_rst_data_in", rd, 32'h0);

      // Short 5-cycle pulse on bit3: rejected only with debounce
      applyStimulus(10'h008);
      tick(5);
      applyStimulus(10'h000);
      tick(LAT + 4);
      busRead(3'd0, rd);
      checkOutput("pulse_data_in", rd, 32'h0);
      busRead(3'd3, rd);
      checkOutput("pulse_cap", rd, PULSE_CAP);
      busWrite(3'd3, 32'h3FF);

      // Sustained level on bit3: DATA_IN follows after CONDLAT cycles
      applyStimulus(10'h008);
      tick(CONDLAT - 1);
      busRead(3'd0, rd);
      checkOutput("level_data_in_early", rd, 32'h0);
      busRead(3'd0, rd);
      checkOutput("level_data_in", rd, 32'h008);
      tick(LAT + 2);
      busRead(3'd3, rd);
      checkOutput("level_cap", rd, 32'h008);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
